// File: rtl/deser_param.sv
// deser_param: serial-to-parallel converter for the UART RX path.
// Collects a run-time-selectable number of sampled bits (LSB- or MSB-first),
// publishes the finished word in a holding register together with its even
// parity, and strobes data_valid for one cycle per completed frame.
//
// Handshake: there is no backpressure. A bit is consumed on every rising
// clk edge where deser_en=1. data_valid is a one-cycle pulse the cycle after
// the final bit; p_data/par_bit are valid from that cycle and remain stable
// until the next completion. new_op_flag discards the frame in progress and
// beats a simultaneous deser_en.
//
// The FSM has two states and is fully observable through busy (SHIFT) and
// bit_cnt.

module deser_param #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  new_op_flag,
  input  logic                  deser_en,
  input  logic                  sampled_bit,
  input  logic [CNT_W-1:0]      frame_len,
  input  logic                  msb_first,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_bit,
  output logic                  busy,
  output logic [CNT_W-1:0]      bit_cnt
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      len_q;
  logic                  msb_q;

  logic [CNT_W-1:0]      eff_len;
  logic [CNT_W-1:0]      cur_len;
  logic                  cur_msb;
  logic [CNT_W-1:0]      cur_cnt;
  logic [CNT_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] word_next;
  logic                  last_bit;

  // Out-of-range frame lengths (0 or above DATA_WIDTH) fall back to full width.
  always_comb begin
    eff_len = MAX_LEN;
    if (frame_len != '0 && frame_len <= MAX_LEN) begin
      eff_len = frame_len;
    end
  end

  // Frame context for the bit arriving now: live inputs when a frame starts,
  // latched values once it is in progress, so mid-frame changes are ignored.
  always_comb begin
    cur_len = len_q;
    cur_msb = msb_q;
    cur_cnt = bit_cnt;
    if (state == IDLE) begin
      cur_len = eff_len;
      cur_msb = msb_first;
      cur_cnt = '0;
    end
    wr_idx   = cur_msb ? (cur_len - ONE - cur_cnt) : cur_cnt;
    last_bit = (cur_cnt == (cur_len - ONE));
  end

  // Word with the current bit written at its final position. Unwritten
  // positions are still zero, which keeps the result right-aligned.
  always_comb begin
    word_next = (state == IDLE) ? '0 : shreg;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (CNT_W'(i) == wr_idx) begin
        word_next[i] = sampled_bit;
      end
    end
  end

  // Frame FSM, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      len_q      <= MAX_LEN;
      msb_q      <= 1'b0;
      p_data     <= '0;
      par_bit    <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (new_op_flag) begin
        // Abort: drop the partial frame, keep the last published word.
        state   <= IDLE;
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (deser_en) begin
        if (state == IDLE) begin
          len_q <= eff_len;
          msb_q <= msb_first;
        end
        if (last_bit) begin
          p_data     <= word_next;
          par_bit    <= ^word_next;
          data_valid <= 1'b1;
          shreg      <= '0;
          bit_cnt    <= '0;
          state      <= IDLE;
        end else begin
          shreg   <= word_next;
          bit_cnt <= cur_cnt + ONE;
          state   <= SHIFT;
        end
      end
    end
  end

  assign busy = (state == SHIFT);

`ifndef SYNTHESIS
  // Structural invariants of the frame FSM.
  a_cnt_in_range : assert property (@(posedge clk) disable iff (!rst)
    busy |-> (bit_cnt != '0 && bit_cnt < len_q));
  a_idle_clear : assert property (@(posedge clk) disable iff (!rst)
    !busy |-> (bit_cnt == '0 && shreg == '0));
  a_right_aligned : assert property (@(posedge clk) disable iff (!rst)
    busy |-> ((shreg >> len_q) == '0));
`endif

endmodule

// File: tb/tb_deser_param.sv
// Directed bench for deser_param: drivers push expected {par_bit, p_data}
// into a queue, a negedge monitor pops and compares on every data_valid.

module tb_deser_param;

  localparam int DW = 8;
  localparam int CW = $clog2(DW + 1);

  logic          clk;
  logic          rst;
  logic          new_op_flag;
  logic          deser_en;
  logic          sampled_bit;
  logic [CW-1:0] frame_len;
  logic          msb_first;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_bit;
  logic          busy;
  logic [CW-1:0] bit_cnt;

  logic [DW:0]   exp_q[$];
  int            checks;
  int            errors;
  int            pulses;
  int            pushed;
  logic [DW-1:0] prev_p;

  deser_param #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .new_op_flag (new_op_flag),
    .deser_en    (deser_en),
    .sampled_bit (sampled_bit),
    .frame_len   (frame_len),
    .msb_first   (msb_first),
    .p_data      (p_data),
    .data_valid  (data_valid),
    .par_bit     (par_bit),
    .busy        (busy),
    .bit_cnt     (bit_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (data_valid) begin
        pulses++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got p_data %0h, expected no data_valid", p_data);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          check("p_data", 32'(p_data), 32'(e[DW-1:0]));
          check("par_bit", 32'(par_bit), 32'(e[DW]));
        end
      end else begin
        check("p_data_hold", 32'(p_data), 32'(prev_p));
      end
    end
    prev_p = p_data;
  end

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    deser_en = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic b, input int gap);
    deser_en = 1'b0;
    repeat (gap) tick();
    deser_en    = 1'b1;
    sampled_bit = b;
    tick();
    deser_en = 1'b0;
  endtask

  // Sends the first nbits of a right-aligned word of frame length len.
  // nbits < 0 means the whole frame; expect pushes the scoreboard entry.
  task automatic send_frame(input logic [DW-1:0] word, input int len, input logic msb,
                            input int gap_max, input logic scramble, input logic expect_out,
                            input int nbits);
    int eff;
    int n;
    logic b;
    eff = (len >= 1 && len <= DW) ? len : DW;
    n   = (nbits < 0) ? eff : nbits;
    frame_len = CW'(len);
    msb_first = msb;
    if (expect_out) begin
      exp_q.push_back({^word, word});
      pushed++;
    end
    for (int k = 0; k < n; k++) begin
      b = msb ? word[eff-1-k] : word[k];
      send_bit(b, $urandom_range(0, gap_max));
      if (k == 0 && scramble) begin
        frame_len = CW'($urandom_range(1, DW - 1));
        msb_first = ~msb;
      end
    end
  endtask

  initial begin
    int p0;
    checks = 0; errors = 0; pulses = 0; pushed = 0;
    rst = 1'b0; new_op_flag = 1'b0; deser_en = 1'b0; sampled_bit = 1'b0;
    frame_len = CW'(DW); msb_first = 1'b0;

    // T1: reset with traffic present
    deser_en = 1'b1; sampled_bit = 1'b1; new_op_flag = 1'b0;
    repeat (3) tick();
    check("rst_p_data", 32'(p_data), 32'h0);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_par_bit", 32'(par_bit), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_bit_cnt", 32'(bit_cnt), 32'h0);
    deser_en = 1'b0;
    rst = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_bit_cnt", 32'(bit_cnt), 32'h0);

    // T2: LSB-first, 8 bits -> 0x4D, parity 0
    send_frame(8'h4D, 8, 1'b0, 0, 1'b0, 1'b1, -1);
    idle(2);
    check("t2_pulses", 32'(pulses), 32'd1);
    check("t2_p_data", 32'(p_data), 32'h4D);

    // Reset mid-frame clears everything immediately
    send_frame(8'hFF, 8, 1'b0, 0, 1'b0, 1'b0, 3);
    check("mid_busy", 32'(busy), 32'h1);
    check("mid_bit_cnt", 32'(bit_cnt), 32'd3);
    rst = 1'b0;
    #1;
    check("arst_p_data", 32'(p_data), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_bit_cnt", 32'(bit_cnt), 32'h0);
    check("arst_par_bit", 32'(par_bit), 32'h0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // T3: MSB-first len 5 -> 0x16 parity 1; then len 0 forced to 8
    send_frame(8'h16, 5, 1'b1, 1, 1'b0, 1'b1, -1);
    idle(1);
    check("t3_busy_after", 32'(busy), 32'h0);
    send_frame(8'hFF, 0, 1'b0, 1, 1'b0, 1'b1, -1);
    idle(2);
    check("t3_len0_p_data", 32'(p_data), 32'hFF);

    // T4: back-to-back frames with random gaps, mid-frame len/mode changes ignored
    p0 = pulses;
    send_frame(8'hA5, 8, 1'b0, 3, 1'b1, 1'b1, -1);
    send_frame(8'h3C, 8, 1'b0, 3, 1'b1, 1'b1, -1);
    send_frame(8'hC3, 8, 1'b1, 0, 1'b0, 1'b1, -1);
    idle(2);
    check("t4_pulses", 32'(pulses - p0), 32'd3);
    check("t4_p_data", 32'(p_data), 32'hC3);

    // T5: abort after 4 bits of 0xF0
    p0 = pulses;
    send_frame(8'hF0, 8, 1'b0, 0, 1'b0, 1'b0, 4);
    check("t5_cnt_before", 32'(bit_cnt), 32'd4);
    new_op_flag = 1'b1;
    tick();
    new_op_flag = 1'b0;
    check("t5_bit_cnt", 32'(bit_cnt), 32'd0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_p_data_kept", 32'(p_data), 32'hC3);
    idle(3);
    check("t5_no_pulse", 32'(pulses - p0), 32'd0);
    send_frame(8'h81, 8, 1'b0, 1, 1'b0, 1'b1, -1);
    idle(2);
    check("t5_p_data", 32'(p_data), 32'h81);

    // T6: new_op_flag coinciding with the final bit discards the frame
    p0 = pulses;
    send_frame(8'h55, 8, 1'b0, 0, 1'b0, 1'b0, 7);
    deser_en = 1'b1; sampled_bit = 1'b0; new_op_flag = 1'b1;
    tick();
    deser_en = 1'b0; new_op_flag = 1'b0;
    check("t6_data_valid", 32'(data_valid), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_bit_cnt", 32'(bit_cnt), 32'h0);
    check("t6_p_data_kept", 32'(p_data), 32'h81);
    idle(2);
    check("t6_no_pulse", 32'(pulses - p0), 32'd0);

    // len=1 frame completes one cycle after its single bit
    frame_len = CW'(1); msb_first = 1'b0;
    exp_q.push_back({1'b1, 8'h01});
    pushed++;
    deser_en = 1'b1; sampled_bit = 1'b1;
    tick();
    deser_en = 1'b0;
    check("len1_data_valid", 32'(data_valid), 32'h1);
    check("len1_p_data", 32'(p_data), 32'h01);
    check("len1_busy", 32'(busy), 32'h0);
    tick();
    check("len1_pulse_width", 32'(data_valid), 32'h0);

    idle(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("total_pulses", 32'(pulses), 32'(pushed));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
